// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined SIMD ALU: op codes, result form and lane size.
// No logic or latency of its own; imported by alu_pipe and alu_lane_core.
// No handshake of its own; the importing modules carry the flow control.
package alu_pkg;

   // operation codes
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_SLT  = 3'b101;
   localparam logic [2:0] OP_ADDS = 3'b110;
   localparam logic [2:0] OP_SUBS = 3'b111;

   // result form
   localparam logic FORM_LANE = 1'b0;   // Y1 = A op B, Y2 = C op D
   localparam logic FORM_WIDE = 1'b1;   // {Y1,Y2} = A +/- B +/- C

   // lane size; any code above VEC_16 means one full-width lane
   localparam logic [1:0] VEC_8    = 2'd0;
   localparam logic [1:0] VEC_16   = 2'd1;
   localparam logic [1:0] VEC_FULL = 2'd2;

endpackage

// File: rtl/alu_lane_core.sv
// Combinational SIMD engine for one operand pair: y = a op b in 8/16/WIDTH-bit lanes.
// Latency 0 (pure combinational); sits in front of the stage-0 register of alu_pipe.
// No flow control; the enclosing pipeline decides when the result is captured.
// Ports: op/vec select operation and lane size, a/b operands, y result,
//        ovf = any lane overflowed (ADD/SUB) or saturated (ADDS/SUBS).
module alu_lane_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic [2:0]       op,
   input  logic [1:0]       vec,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             ovf
);

   // Two guard bits so a full-width sum or difference never wraps internally.
   localparam int SW = WIDTH + 2;
   localparam logic signed [SW-1:0] ONE = 1;

   // One lane of width lw; operands arrive zero-extended in the low lw bits.
   // Only the low lw bits of fy are meaningful to the caller.
   function automatic void lane_op(
      input  logic [2:0]       f_op,
      input  logic [WIDTH-1:0] fa,
      input  logic [WIDTH-1:0] fb,
      input  int               lw,
      output logic [WIDTH-1:0] fy,
      output logic             fovf
   );
      logic signed [SW-1:0] sa, sb, s, hi, lo, sat;
      logic                 out_of_range;
      // sign-extend the lane value from bit lw-1
      sa = signed'({2'b00, fa});
      sa = sa <<< (SW - lw);
      sa = sa >>> (SW - lw);
      sb = signed'({2'b00, fb});
      sb = sb <<< (SW - lw);
      sb = sb >>> (SW - lw);
      hi = (ONE <<< (lw - 1)) - ONE;
      lo = -hi - ONE;
      s  = (f_op == OP_SUB || f_op == OP_SUBS) ? (sa - sb) : (sa + sb);
      out_of_range = (s > hi) || (s < lo);
      sat = (s > hi) ? hi : ((s < lo) ? lo : s);
      fovf = 1'b0;
      case (f_op)
         OP_AND:  fy = fa & fb;
         OP_OR:   fy = fa | fb;
         OP_XOR:  fy = fa ^ fb;
         OP_SLT:  fy = (sa < sb) ? WIDTH'(1) : '0;
         OP_ADDS, OP_SUBS: begin
            fy   = WIDTH'(sat);
            fovf = out_of_range;
         end
         default: begin   // OP_ADD, OP_SUB: wrap, flag signed overflow
            fy   = WIDTH'(s);
            fovf = out_of_range;
         end
      endcase
   endfunction

   always_comb begin
      logic [WIDTH-1:0] ty;
      logic             to;
      y   = '0;
      ovf = 1'b0;
      ty  = '0;
      to  = 1'b0;
      case (vec)
         VEC_8: begin
            for (int i = 0; i < WIDTH/8; i++) begin
               lane_op(op, WIDTH'(a[i*8 +: 8]), WIDTH'(b[i*8 +: 8]), 8, ty, to);
               y[i*8 +: 8] = ty[7:0];
               ovf         = ovf | to;
            end
         end
         VEC_16: begin
            for (int i = 0; i < WIDTH/16; i++) begin
               lane_op(op, WIDTH'(a[i*16 +: 16]), WIDTH'(b[i*16 +: 16]), 16, ty, to);
               y[i*16 +: 16] = ty[15:0];
               ovf           = ovf | to;
            end
         end
         default: begin
            lane_op(op, a, b, WIDTH, ty, to);
            y   = ty;
            ovf = to;
         end
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined SIMD ALU: lanewise or 3-operand wide add/sub, overflow flag and sticky status.
// Latency LATENCY cycles: accepted at edge N, out_valid after edge N+LATENCY-1.
// Valid/ready both sides; stages shuffle forward into holes, in_ready drops once all LATENCY stages hold data.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with op, form, vec, A..D;
//        out_valid/out_ready with Y1, Y2, out_ovf; ovf_sticky status cleared by ovf_clr.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             form,
   input  logic [1:0]       vec,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y1,
   output logic [WIDTH-1:0] Y2,
   output logic             out_ovf,
   output logic             ovf_sticky,
   input  logic             ovf_clr
);

   if (WIDTH < 16 || (WIDTH % 16) != 0) begin : g_bad_width
      $error("alu_pipe: WIDTH must be a multiple of 16 and at least 16");
   end
   if (LATENCY < 1) begin : g_bad_latency
      $error("alu_pipe: LATENCY must be at least 1");
   end

   typedef struct packed {
      logic [WIDTH-1:0] y1;
      logic [WIDTH-1:0] y2;
      logic             ovf;
   } stage_t;

   logic [LATENCY-1:0] stg_vld;
   logic [LATENCY-1:0] stg_adv;
   stage_t             stg_dat [LATENCY];
   stage_t             nxt_dat;

   // ---------------- stage-0 compute ----------------
   logic [WIDTH-1:0]   ly1, ly2;
   logic               lo1, lo2;
   logic [2*WIDTH-1:0] wide_sum;

   alu_lane_core #(.WIDTH(WIDTH)) u_lane_ab (
      .op  (op),
      .vec (vec),
      .a   (A),
      .b   (B),
      .y   (ly1),
      .ovf (lo1)
   );

   alu_lane_core #(.WIDTH(WIDTH)) u_lane_cd (
      .op  (op),
      .vec (vec),
      .a   (C),
      .b   (D),
      .y   (ly2),
      .ovf (lo2)
   );

   always_comb begin
      wide_sum = '0;
      nxt_dat  = '0;
      if (form == FORM_WIDE) begin
         // 2*WIDTH bits hold any sum of three sign-extended operands, so the wide form never overflows
         if (op == OP_ADD) begin
            wide_sum = {{WIDTH{A[WIDTH-1]}}, A} + {{WIDTH{B[WIDTH-1]}}, B}
                     + {{WIDTH{C[WIDTH-1]}}, C};
         end else if (op == OP_SUB) begin
            wide_sum = {{WIDTH{A[WIDTH-1]}}, A} - {{WIDTH{B[WIDTH-1]}}, B}
                     - {{WIDTH{C[WIDTH-1]}}, C};
         end
         nxt_dat.y1  = wide_sum[2*WIDTH-1:WIDTH];
         nxt_dat.y2  = wide_sum[WIDTH-1:0];
         nxt_dat.ovf = 1'b0;
      end else begin
         nxt_dat.y1  = ly1;
         nxt_dat.y2  = ly2;
         nxt_dat.ovf = lo1 | lo2;
      end
   end

   // ---------------- flow control ----------------
   // Walk from the output backwards: a full stage moves if there is a hole
   // anywhere downstream of it or the consumer takes the last entry.
   always_comb begin
      logic room;
      room    = out_ready;
      stg_adv = '0;
      for (int i = LATENCY - 1; i >= 0; i--) begin
         stg_adv[i] = stg_vld[i] & room;
         room       = room | ~stg_vld[i];
      end
   end

   assign in_ready = rst_n & (~stg_vld[0] | stg_adv[0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_vld <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            stg_dat[i] <= '0;
         end
      end else begin
         if (in_ready) begin
            stg_vld[0] <= in_valid;
            if (in_valid) begin
               stg_dat[0] <= nxt_dat;
            end
         end
         for (int i = 1; i < LATENCY; i++) begin
            if (!stg_vld[i] || stg_adv[i]) begin
               stg_vld[i] <= stg_adv[i-1];
               if (stg_adv[i-1]) begin
                  stg_dat[i] <= stg_dat[i-1];
               end
            end
         end
      end
   end

   assign out_valid = stg_vld[LATENCY-1];
   assign Y1        = stg_dat[LATENCY-1].y1;
   assign Y2        = stg_dat[LATENCY-1].y2;
   assign out_ovf   = stg_dat[LATENCY-1].ovf;

   // ---------------- sticky overflow ----------------
   // A new overflow result in the same cycle as a clear wins, so no event is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
      end else if (out_valid && out_ready && out_ovf) begin
         ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
         ovf_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: arithmetic reference model, directed cases and random traffic.
// Expected results are queued at input acceptance and popped on each output handshake.
// Exercises backpressure, output stability while stalled, sticky overflow and mid-flight reset.
module tb_alu_pipe;
   import alu_pkg::*;

   localparam int W = 32;
   localparam int L = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   op = '0;
   logic         form = 1'b0;
   logic [1:0]   vec = '0;
   logic [W-1:0] A = '0, B = '0, C = '0, D = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] Y1, Y2;
   logic         out_ovf;
   logic         ovf_sticky;
   logic         ovf_clr = 1'b0;

   alu_pipe #(.WIDTH(W), .LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .form(form), .vec(vec), .A(A), .B(B), .C(C), .D(D),
      .out_valid(out_valid), .out_ready(out_ready), .Y1(Y1), .Y2(Y2),
      .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   op;
      logic         form;
      logic [1:0]   vec;
      logic [W-1:0] a, b, c, d;
   } bundle_t;

   typedef struct {
      logic [W-1:0] y1, y2;
      logic         ovf;
      int           acc;
      bit           chk_lat;
   } exp_t;

   exp_t         sb[$];
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   bit           m_sticky = 1'b0;
   bit           prev_stall = 1'b0;
   logic [2*W:0] prev_out = '0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: each lane taken as a signed integer, arithmetic done in longint.
   function automatic exp_t model(input bundle_t bd);
      exp_t                e;
      logic signed [2*W-1:0] s;
      longint              lw, mask, hi, lo, ua, ub, sa, sbv, r, res;
      logic [W-1:0]        pa, pb;
      e.y1 = '0; e.y2 = '0; e.ovf = 1'b0; e.acc = 0; e.chk_lat = 1'b0;
      if (bd.form) begin
         if (bd.op == OP_ADD)      s = $signed(bd.a) + $signed(bd.b) + $signed(bd.c);
         else if (bd.op == OP_SUB) s = $signed(bd.a) - $signed(bd.b) - $signed(bd.c);
         else                      s = '0;
         e.y1 = s[2*W-1:W];
         e.y2 = s[W-1:0];
      end else begin
         lw   = (bd.vec == 2'd0) ? 8 : (bd.vec == 2'd1) ? 16 : W;
         mask = (longint'(1) << lw) - 1;
         hi   = (longint'(1) << (lw - 1)) - 1;
         lo   = -hi - 1;
         for (int k = 0; k < 2; k++) begin
            pa  = (k == 0) ? bd.a : bd.c;
            pb  = (k == 0) ? bd.b : bd.d;
            res = 0;
            for (int i = 0; i < W / lw; i++) begin
               ua  = (longint'(pa) >> (i * lw)) & mask;
               ub  = (longint'(pb) >> (i * lw)) & mask;
               sa  = (ua > hi) ? ua - (mask + 1) : ua;
               sbv = (ub > hi) ? ub - (mask + 1) : ub;
               case (bd.op)
                  OP_AND:  r = ua & ub;
                  OP_OR:   r = ua | ub;
                  OP_XOR:  r = ua ^ ub;
                  OP_SLT:  r = (sa < sbv) ? 1 : 0;
                  OP_ADD, OP_SUB: begin
                     r = (bd.op == OP_ADD) ? sa + sbv : sa - sbv;
                     if (r > hi || r < lo) e.ovf = 1'b1;
                  end
                  default: begin
                     r = (bd.op == OP_ADDS) ? sa + sbv : sa - sbv;
                     if (r > hi) begin r = hi; e.ovf = 1'b1; end
                     else if (r < lo) begin r = lo; e.ovf = 1'b1; end
                  end
               endcase
               res = res | ((r & mask) << (i * lw));
            end
            if (k == 0) e.y1 = W'(res);
            else        e.y2 = W'(res);
         end
      end
      return e;
   endfunction

   // One clock of stimulus: drive after the falling edge, decide acceptance just before the rising edge.
   task automatic step(input bit vld, input bundle_t bd, input bit ordy, input bit clr,
                       input bit clr_on_valid, input bit lat, output bit acc);
      exp_t e;
      @(negedge clk);
      in_valid  = vld;
      op = bd.op; form = bd.form; vec = bd.vec;
      A = bd.a; B = bd.b; C = bd.c; D = bd.d;
      out_ready = ordy;
      ovf_clr   = clr | (clr_on_valid & out_valid);
      #4;
      acc = vld && in_ready;
      if (acc) begin
         e = model(bd);
         e.acc = cyc + 1;
         e.chk_lat = lat;
         sb.push_back(e);
      end
   endtask

   task automatic send(input bundle_t bd, input bit ordy, input bit lat);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         step(1'b1, bd, ordy, 1'b0, 1'b0, lat, acc);
         n++;
      end
      if (!acc) check("send_timeout", 0, 1);
   endtask

   task automatic idle(input int n, input bit ordy, input bit clr, input bit clr_on_valid);
      bundle_t z;
      bit acc;
      z = '{op: 3'd0, form: 1'b0, vec: 2'd0, a: '0, b: '0, c: '0, d: '0};
      for (int i = 0; i < n; i++) step(1'b0, z, ordy, clr, clr_on_valid, 1'b0, acc);
   endtask

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return '1;
         2: return {1'b0, {(W-1){1'b1}}};
         3: return {1'b1, {(W-1){1'b0}}};
         4: return {(W/8){8'h7f}};
         5: return {(W/8){8'h80}};
         default: return W'($urandom);
      endcase
   endfunction

   function automatic bundle_t rand_bundle();
      bundle_t bd;
      bd.op   = 3'($urandom_range(0, 7));
      bd.form = ($urandom_range(0, 4) == 0);
      bd.vec  = 2'($urandom_range(0, 3));
      bd.a = rand_operand(); bd.b = rand_operand();
      bd.c = rand_operand(); bd.d = rand_operand();
      return bd;
   endfunction

   // Monitor: samples just before each rising edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (rst_n) begin
            check("sticky", ovf_sticky, m_sticky);
            if (prev_stall)
               check("stall_stable", {out_valid, Y1, Y2, out_ovf}, {1'b1, prev_out});
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_output: got Y1=%0h Y2=%0h with no pending bundle", Y1, Y2);
               end else begin
                  e = sb.pop_front();
                  check("result", {Y1, Y2, out_ovf}, {e.y1, e.y2, e.ovf});
                  if (e.chk_lat) check("latency", cyc - e.acc, L - 1);
                  if (e.ovf) m_sticky = 1'b1;
                  else if (ovf_clr) m_sticky = 1'b0;
               end
            end else if (ovf_clr) begin
               m_sticky = 1'b0;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {Y1, Y2, out_ovf};
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      bundle_t bd;
      bit      acc;
      int      nacc;
      int      k;
      bundle_t bp[6];

      // reset state
      #2;
      check("reset_ctrl", {out_valid, in_ready, ovf_sticky, out_ovf}, 4'b0000);
      check("reset_y", {Y1, Y2}, 64'd0);
      #6 rst_n = 1'b1;
      #1 check("ready_after_reset", in_ready, 1'b1);

      // wide add and subtract
      bd = '{op: OP_ADD, form: FORM_WIDE, vec: 2'd2, a: 32'd1, b: 32'd2, c: 32'd3, d: 32'd2};
      send(bd, 1'b1, 1'b1);
      idle(4, 1'b1, 1'b0, 1'b0);
      bd.op = OP_SUB;
      send(bd, 1'b1, 1'b1);
      idle(4, 1'b1, 1'b0, 1'b0);

      // byte-lane add with overflow in two lanes
      bd = '{op: OP_ADD, form: FORM_LANE, vec: VEC_8, a: 32'h7F01_FF80, b: 32'h0101_0180, c: '0, d: '0};
      send(bd, 1'b1, 1'b1);
      idle(4, 1'b1, 1'b0, 1'b0);
      check("sticky_after_ovf", ovf_sticky, 1'b1);

      // halfword saturating add; clear asserted exactly on the overflow result cycle
      bd = '{op: OP_ADDS, form: FORM_LANE, vec: VEC_16, a: 32'h7FFF_8000, b: 32'h0001_FFFF, c: '0, d: '0};
      send(bd, 1'b1, 1'b1);
      idle(4, 1'b1, 1'b0, 1'b0);
      send(bd, 1'b1, 1'b0);
      idle(4, 1'b1, 1'b0, 1'b1);
      check("sticky_set_wins", ovf_sticky, 1'b1);
      idle(1, 1'b1, 1'b1, 1'b0);
      idle(1, 1'b1, 1'b0, 1'b0);
      check("sticky_cleared", ovf_sticky, 1'b0);

      // backpressure: out_ready low for five cycles while six bundles are offered
      for (int i = 0; i < 6; i++) begin
         bp[i] = '{op: OP_ADD, form: FORM_LANE, vec: 2'($urandom_range(0, 3)),
                   a: W'($urandom), b: W'($urandom), c: W'($urandom), d: W'($urandom)};
      end
      k = 0;
      nacc = 0;
      for (int cycn = 0; cycn < 5; cycn++) begin
         step(1'b1, bp[k], 1'b0, 1'b0, 1'b0, 1'b0, acc);
         if (acc) begin k++; nacc++; end
      end
      check("bp_accepts", nacc, L);
      check("bp_in_ready_low", in_ready, 1'b0);
      while (k < 6) begin
         send(bp[k], 1'b1, 1'b0);
         k++;
      end
      idle(L + 3, 1'b1, 1'b0, 1'b0);
      check("bp_drained", sb.size(), 0);

      // reset with bundles in flight and the sticky bit set
      bd = '{op: OP_ADD, form: FORM_LANE, vec: VEC_8, a: 32'h7F01_FF80, b: 32'h0101_0180, c: '0, d: '0};
      send(bd, 1'b1, 1'b0);
      idle(4, 1'b1, 1'b0, 1'b0);
      send(bd, 1'b0, 1'b0);
      send(bd, 1'b0, 1'b0);
      idle(1, 1'b0, 1'b0, 1'b0);
      check("pre_reset_valid", {out_valid, ovf_sticky}, 2'b11);
      @(negedge clk);
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("mid_reset_ctrl", {out_valid, ovf_sticky, in_ready, out_ovf}, 4'b0000);
      check("mid_reset_y", {Y1, Y2}, 64'd0);
      #1 rst_n = 1'b1;
      sb.delete();
      m_sticky   = 1'b0;
      prev_stall = 1'b0;
      #1 check("ready_after_midreset", in_ready, 1'b1);
      idle(4, 1'b1, 1'b0, 1'b0);
      bd = '{op: OP_XOR, form: FORM_LANE, vec: VEC_16, a: 32'h1234_5678, b: 32'h0F0F_F0F0, c: 32'hAAAA_5555, d: 32'h5555_AAAA};
      send(bd, 1'b1, 1'b1);
      idle(4, 1'b1, 1'b0, 1'b0);

      // random traffic with random backpressure and occasional clears
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 4) != 0, rand_bundle(), $urandom_range(0, 3) != 0,
              $urandom_range(0, 19) == 0, 1'b0, 1'b0, acc);
      end
      idle(L + 6, 1'b1, 1'b0, 1'b0);
      check("final_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
